// File: rtl/dds_phase_core_if.sv
// rtl/dds_phase_core_if.sv - control and sample bus of the DDS phase core
`timescale 1ns/1ps

interface dds_phase_core_if #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 12
);
  logic [PHASE_W-1:0] fcw_in;
  logic               fcw_valid;
  logic               fcw_ready;
  logic [1:0]         wave_sel;
  logic               sync_en;
  logic [PHASE_W-1:0] phase;
  logic [OUT_W-1:0]   wave_out;
  logic               out_valid;

  modport master (
    output fcw_in, fcw_valid, wave_sel, sync_en,
    input  fcw_ready, phase, wave_out, out_valid
  );

  modport slave (
    input  fcw_in, fcw_valid, wave_sel, sync_en,
    output fcw_ready, phase, wave_out, out_valid
  );
endinterface

// File: rtl/dds_phase_core.sv
// rtl/dds_phase_core.sv - sample-rate phase accumulator and waveform generator
`timescale 1ns/1ps

module dds_phase_core #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 12
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               clk_10k,
  input  logic               clk_05,
  dds_phase_core_if.slave    dds
);

  logic               clk_10k_d;
  logic               clk_05_d;
  logic               tick;
  logic               sync;
  logic               tick_d;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] active_fcw;
  logic [PHASE_W-1:0] pending;
  logic               pending_valid;
  logic [PHASE_W-1:0] fcw_next;
  logic               fcw_accept;
  logic [OUT_W-1:0]   wave_calc;
  logic [OUT_W-1:0]   wave_q;
  logic               out_valid_q;
  logic [OUT_W-1:0]   p_slice;
  logic [OUT_W-1:0]   t_slice;

  // Divider outputs are plain data here; edges come from one-cycle delay copies.
  assign tick       = clk_10k & ~clk_10k_d;
  assign sync       = clk_05 & ~clk_05_d & dds.sync_en;
  assign fcw_next   = pending_valid ? pending : active_fcw;
  assign dds.fcw_ready = ~pending_valid & ~rst;
  assign fcw_accept = dds.fcw_valid & dds.fcw_ready;

  // Edge detectors, single-entry FCW buffer and phase accumulator.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      // Track live levels during reset so release never looks like an edge.
      clk_10k_d     <= clk_10k;
      clk_05_d      <= clk_05;
      phase_q       <= '0;
      active_fcw    <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      tick_d        <= 1'b0;
    end else begin
      clk_10k_d <= clk_10k;
      clk_05_d  <= clk_05;
      tick_d    <= tick;
      if (tick) begin
        active_fcw    <= fcw_next;
        pending_valid <= 1'b0;
        phase_q       <= (sync ? '0 : phase_q) + fcw_next;
      end else if (sync) begin
        phase_q <= '0;
      end
      // Placed after the tick clear: a word arriving on a tick waits for the next one.
      if (fcw_accept) begin
        pending       <= dds.fcw_in;
        pending_valid <= 1'b1;
      end
    end
  end

  assign p_slice = phase_q[PHASE_W-1 -: OUT_W];
  assign t_slice = phase_q[PHASE_W-2 -: OUT_W];

  // Map the updated phase onto the selected signed waveform.
  always_comb begin
    wave_calc = '0;
    unique case (dds.wave_sel)
      2'b00: wave_calc = {~p_slice[OUT_W-1], p_slice[OUT_W-2:0]};
      2'b01: wave_calc = phase_q[PHASE_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
      2'b10: begin
        wave_calc = phase_q[PHASE_W-1] ? ~t_slice : t_slice;
        wave_calc = {~wave_calc[OUT_W-1], wave_calc[OUT_W-2:0]};
      end
      default: wave_calc = '0;
    endcase
  end

  // Register one sample per tick, one cycle after the phase has moved.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wave_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= tick_d;
      if (tick_d) begin
        wave_q <= wave_calc;
      end
    end
  end

  assign dds.phase     = phase_q;
  assign dds.wave_out  = wave_q;
  assign dds.out_valid = out_valid_q;

endmodule

// File: tb/tb_dds_phase_core.sv
// tb/tb_dds_phase_core.sv - scoreboard bench for dds_phase_core
`timescale 1ns/1ps

module tb_dds_phase_core;

  localparam int PW = 24;
  localparam int OW = 12;

  typedef struct {
    logic [OW-1:0] wave;
    int            cyc;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst;
  logic clk_10k;
  logic clk_05;

  dds_phase_core_if #(.PHASE_W(PW), .OUT_W(OW)) dds_bus ();

  dds_phase_core #(.PHASE_W(PW), .OUT_W(OW)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clk_10k (clk_10k),
    .clk_05  (clk_05),
    .dds     (dds_bus)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  exp_t sb[$];

  logic [PW-1:0] m_phase;
  logic [PW-1:0] m_active;
  logic [PW-1:0] m_pend;
  bit            m_pend_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] exp_wave(input logic [PW-1:0] ph, input logic [1:0] sel);
    int p;
    int t;
    p = int'(ph >> (PW - OW));
    t = int'((ph >> (PW - OW - 1)) & 24'hFFF);
    case (sel)
      2'd0: return OW'((p + 2048) % 4096);
      2'd1: return ph[PW-1] ? 12'h800 : 12'h7FF;
      2'd2: begin
        if (ph[PW-1]) t = 4095 - t;
        return OW'((t + 2048) % 4096);
      end
      default: return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_fcw(input logic [PW-1:0] w);
    int k;
    k = 0;
    dds_bus.fcw_in    = w;
    dds_bus.fcw_valid = 1'b1;
    while (!dds_bus.fcw_ready && k < 50) begin
      step();
      k++;
    end
    if (k == 50) check("fcw_ready_timeout", {31'd0, dds_bus.fcw_ready}, 32'd1);
    step();
    dds_bus.fcw_valid = 1'b0;
    m_pend   = w;
    m_pend_v = 1'b1;
  endtask

  task automatic do_tick(input bit with_word, input logic [PW-1:0] word, input bit with_sync);
    logic [PW-1:0] nxt;
    exp_t e;
    clk_10k = 1'b1;
    if (with_sync) clk_05 = 1'b1;
    if (with_word) begin
      dds_bus.fcw_in    = word;
      dds_bus.fcw_valid = 1'b1;
    end
    nxt      = m_pend_v ? m_pend : m_active;
    m_active = nxt;
    m_pend_v = 1'b0;
    m_phase  = ((with_sync && dds_bus.sync_en) ? '0 : m_phase) + nxt;
    if (with_word) begin
      m_pend   = word;
      m_pend_v = 1'b1;
    end
    e.wave = exp_wave(m_phase, dds_bus.wave_sel);
    e.cyc  = cyc + 2;
    sb.push_back(e);
    step();
    check("phase", 32'(dds_bus.phase), 32'(m_phase));
    clk_10k = 1'b0;
    clk_05  = 1'b0;
    if (with_word) dds_bus.fcw_valid = 1'b0;
    step();
  endtask

  task automatic do_sync();
    clk_05 = 1'b1;
    if (dds_bus.sync_en) m_phase = '0;
    step();
    check("sync_phase", 32'(dds_bus.phase), 32'(m_phase));
    clk_05 = 1'b0;
    step();
  endtask

  always @(negedge sys_clk) begin
    if (dds_bus.out_valid === 1'b1) begin
      exp_t e;
      n_pulse++;
      if (sb.size() == 0) begin
        check("spurious_valid", {31'd0, dds_bus.out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wave_out", 32'(dds_bus.wave_out), 32'(e.wave));
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses0;
    rst = 1'b1;
    clk_10k = 1'b0;
    clk_05  = 1'b0;
    dds_bus.fcw_in    = '0;
    dds_bus.fcw_valid = 1'b0;
    dds_bus.wave_sel  = 2'b00;
    dds_bus.sync_en   = 1'b0;
    m_phase = '0; m_active = '0; m_pend = '0; m_pend_v = 1'b0;
    repeat (3) step();
    check("rst_phase", 32'(dds_bus.phase), 32'd0);
    check("rst_wave", 32'(dds_bus.wave_out), 32'd0);
    check("rst_valid", {31'd0, dds_bus.out_valid}, 32'd0);
    check("rst_ready", {31'd0, dds_bus.fcw_ready}, 32'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", {31'd0, dds_bus.fcw_ready}, 32'd1);

    // Saw over one full phase revolution, wrapping back to zero.
    send_fcw(24'h100000);
    pulses0 = n_pulse;
    for (int i = 0; i < 16; i++) do_tick(1'b0, '0, 1'b0);
    repeat (3) step();
    check("pulse_count", n_pulse - pulses0, 32'd16);
    check("wrap_phase", 32'(dds_bus.phase), 32'd0);

    // Triangle then square over full revolutions.
    dds_bus.wave_sel = 2'b10;
    for (int i = 0; i < 16; i++) do_tick(1'b0, '0, 1'b0);
    dds_bus.wave_sel = 2'b01;
    for (int i = 0; i < 16; i++) do_tick(1'b0, '0, 1'b0);
    dds_bus.wave_sel = 2'b11;
    do_tick(1'b0, '0, 1'b0);
    dds_bus.wave_sel = 2'b00;
    repeat (2) step();

    // Near-full-scale FCW from zero: silent modulo wrap.
    for (int i = 0; i < 15; i++) do_tick(1'b0, '0, 1'b0);
    check("phase_zero_before_max", 32'(dds_bus.phase), 32'd0);
    send_fcw(24'hFFFFFF);
    do_tick(1'b0, '0, 1'b0);
    check("max_fcw_1", 32'(dds_bus.phase), 32'hFFFFFF);
    do_tick(1'b0, '0, 1'b0);
    check("max_fcw_2", 32'(dds_bus.phase), 32'hFFFFFE);

    // Handshake: A pending, B back-pressured until the tick consumes A.
    send_fcw(24'h012345);
    dds_bus.fcw_in    = 24'h054321;
    dds_bus.fcw_valid = 1'b1;
    step();
    check("b_blocked_1", {31'd0, dds_bus.fcw_ready}, 32'd0);
    step();
    check("b_blocked_2", {31'd0, dds_bus.fcw_ready}, 32'd0);
    do_tick(1'b0, '0, 1'b0);
    m_pend   = 24'h054321;
    m_pend_v = 1'b1;
    check("b_pending", {31'd0, dds_bus.fcw_ready}, 32'd0);
    dds_bus.fcw_valid = 1'b0;
    do_tick(1'b0, '0, 1'b0);
    do_tick(1'b1, 24'h0ABCDE, 1'b0);
    check("c_pending", {31'd0, dds_bus.fcw_ready}, 32'd0);
    do_tick(1'b0, '0, 1'b0);

    // Hard-sync alone, disabled, and coincident with a tick.
    dds_bus.sync_en = 1'b1;
    do_sync();
    do_tick(1'b0, '0, 1'b0);
    dds_bus.sync_en = 1'b0;
    do_sync();
    do_tick(1'b0, '0, 1'b0);
    dds_bus.sync_en = 1'b1;
    do_tick(1'b0, '0, 1'b1);
    dds_bus.sync_en = 1'b0;
    repeat (2) step();

    // Reset mid-stream with clk_10k high and a word pending.
    send_fcw(24'h333333);
    step();
    rst     = 1'b1;
    clk_10k = 1'b1;
    step();
    check("mid_rst_phase", 32'(dds_bus.phase), 32'd0);
    check("mid_rst_wave", 32'(dds_bus.wave_out), 32'd0);
    check("mid_rst_valid", {31'd0, dds_bus.out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, dds_bus.fcw_ready}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_ready", {31'd0, dds_bus.fcw_ready}, 32'd1);
    check("post_rst_phase", 32'(dds_bus.phase), 32'd0);
    step();
    step();
    check("no_false_tick", 32'(dds_bus.phase), 32'd0);
    clk_10k = 1'b0;
    m_phase = '0; m_active = '0; m_pend = '0; m_pend_v = 1'b0;
    step();
    do_tick(1'b0, '0, 1'b0);
    check("pending_dropped", 32'(dds_bus.phase), 32'd0);

    repeat (4) step();
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_phase_core.md
Name: dds_phase_core

Overview:
- Sample-rate DDS core. Consumes the 10 kHz sample clock and 0.5 Hz clock from the divider stage as level signals in the sys_clk domain, and detects their rising edges internally.
- Each 10 kHz rising edge advances a phase accumulator by a frequency control word (FCW) and produces one signed waveform sample (saw, square, triangle or mute) for the downstream DAC/PWM stage.
- Optional hard-sync: the 0.5 Hz rising edge resets the phase.

Parameters:
- PHASE_W, 24, accumulator and FCW width; accumulation is modulo 2^PHASE_W.
- OUT_W, 12, output sample width, two's complement; OUT_W <= PHASE_W-1.

Ports:
- sys_clk, in, 1, 100 MHz system clock; the only clock.
- rst, in, 1, synchronous active-high reset.
- clk_10k, in, 1, 10 kHz square wave from the divider, treated as data; rising edge = sample tick.
- clk_05, in, 1, 0.5 Hz square wave from the divider, treated as data; rising edge = sync event.
- fcw_in, in, PHASE_W, new frequency control word.
- fcw_valid, in, 1, fcw_in is valid.
- fcw_ready, out, 1, core can accept a word.
- wave_sel, in, 2, 00 saw / 01 square / 10 triangle / 11 mute.
- sync_en, in, 1, enables phase reset on the clk_05 rising edge.
- phase, out, PHASE_W, current accumulator value.
- wave_out, out, OUT_W, signed sample.
- out_valid, out, 1, one-cycle pulse when wave_out updates.

Behaviour:
- Single clock: sys_clk. Reset is synchronous and active-high on rst.
- Reset values: phase=0, active_fcw=0, pending cleared, wave_out=0, out_valid=0.
- Edge-detect registers clk_10k_d and clk_05_d load the live input values while rst=1, so there is no spurious edge on reset release.
- Tick definition: tick = clk_10k & ~clk_10k_d; sync = clk_05 & ~clk_05_d & sync_en. Both are combinational, using registered delay copies.
- fcw_ready = ~pending_valid & ~rst.
- Handshake: a word transfers on fcw_valid & fcw_ready and is stored in pending; pending_valid is set. A second word is back-pressured until the pending word is consumed.
- fcw_next = pending_valid ? pending : active_fcw.
- On a tick cycle:
  - active_fcw <= fcw_next, and pending_valid is cleared.
  - phase <= (sync ? 0 : phase) + fcw_next, modulo 2^PHASE_W.
- A word accepted in the same cycle as a tick is not used by that tick. It goes to pending and is applied at the following tick.
- Sync without tick: phase <= 0.
- Simultaneous sync and tick: phase <= fcw_next.
- Wave stage: in the cycle after a tick, wave_out is computed from the updated phase and out_valid=1. In all other cycles out_valid=0 and wave_out holds.
- Latency: first cycle clk_10k=1 is cycle n; phase updates at n+1; wave_out and out_valid at n+2.
- wave_sel is sampled in the wave-update cycle.
- Waveform mapping, with p = phase[PHASE_W-1 -: OUT_W]:
  - saw: p with its MSB inverted (offset-binary to two's complement).
  - square: phase MSB=0 -> 2^(OUT_W-1)-1; MSB=1 -> -2^(OUT_W-1).
  - triangle: t = phase[PHASE_W-2 -: OUT_W], bitwise inverted when phase MSB=1; output is t with its MSB inverted.
  - mute: 0.
- Wrap-around: phase overflow is discarded silently, with no flag.
- FCW=0 holds phase constant; out_valid still pulses every tick.
- Reset mid-operation: all state returns to reset values on the next edge, and any pending word is discarded.

Test Plan:
- Reset, then FCW=0x100000, wave_sel=00, 16 clk_10k rising edges -> phase steps 0x100000, 0x200000 … wraps to 0x000000 on tick 16. First wave_out=0x900; out_valid pulses exactly 16 times, each 2 cycles after the edge.
- Same FCW, wave_sel=10 -> first sample 0xA00. At phase 0x900000 (MSB=1), t=~0x200=0xDFF, wave_out=0x5FF. With wave_sel=01: 0x7FF while phase<0x800000, 0x800 after.
- FCW=0xFFFFFF from phase 0 -> phase 0xFFFFFF, then 0xFFFFFE (wrap, no flag).
- Handshake: word A accepted, then word B held valid -> fcw_ready=0 until the next tick. That tick uses A; B is accepted the cycle after and is used at the following tick. A word accepted on a tick cycle is applied one tick later.
- sync_en=1 with clk_05 rising in a non-tick cycle -> phase=0 next cycle. Coincident with a tick -> phase=FCW. With sync_en=0 -> no effect.
- Assert rst mid-stream with clk_10k high and a pending word -> all outputs 0, pending dropped. After release with clk_10k still high, no tick occurs until the next genuine rising edge.
